// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbiter and mux with a one-word registered output stage.
// Each cycle the output register can take a new word, the arbiter picks one
// requesting channel. It uses round-robin (ARB_MODE=0) or lowest-index-first
// (ARB_MODE=1). That channel's data is captured in the output register.
//
// Ports
//   clk_in      : clock, rising edge
//   reset_n_in  : asynchronous active-low reset
//   req_in      : per-channel request, bit i = channel i
//   data_in     : packed channel data, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   lock_in     : keep granting the last-granted channel while it still requests
//   ready_in    : downstream takes data_out this cycle
//   grant_out   : one-hot (or zero) channel consumed this cycle, combinational
//   valid_out   : data_out/sel_out hold a word
//   data_out    : registered selected data
//   sel_out     : registered index of the channel behind data_out
module rr_arb_mux #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_CH    = 8,
    parameter int ARB_MODE  = 0
) (
    input  logic                                           clk_in,
    input  logic                                           reset_n_in,
    input  logic [NUM_CH-1:0]                              req_in,
    input  logic [NUM_CH*BUS_WIDTH-1:0]                    data_in,
    input  logic                                           lock_in,
    input  logic                                           ready_in,
    output logic [NUM_CH-1:0]                              grant_out,
    output logic                                           valid_out,
    output logic [BUS_WIDTH-1:0]                           data_out,
    output logic [((NUM_CH > 2) ? $clog2(NUM_CH) : 1)-1:0] sel_out
);

    localparam int SEL_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam logic [SEL_W:0]   NCH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    logic [SEL_W-1:0] ptr, last;
    logic [SEL_W-1:0] rr_idx, fp_idx, win_idx, rot_off;
    logic [SEL_W:0]   rr_sum;
    logic [2*NUM_CH-1:0] req_sh;
    logic [NUM_CH-1:0]   req_rot;
    logic load_ok, grant_en;

    // Unpack channel data so the winner can be picked by plain array index.
    logic [BUS_WIDTH-1:0] ch_data [NUM_CH];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_unpack
            assign ch_data[g] = data_in[g*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    assign valid_out = (state == FULL);
    assign load_ok   = (state == EMPTY) || ready_in;
    // Gating with reset keeps grant_out quiet while reset is held.
    assign grant_en  = reset_n_in && load_ok && (|req_in);

    // Round-robin: rotate requests so ptr lands at bit 0. The lowest set bit of
    // the rotated vector is the offset from ptr. Add it back modulo NUM_CH.
    assign req_sh  = {req_in, req_in} >> ptr;
    assign req_rot = req_sh[NUM_CH-1:0];

    always_comb begin
        rot_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) rot_off = SEL_W'(k);
        end
        rr_sum = {1'b0, ptr} + {1'b0, rot_off};
        if (rr_sum >= NCH_W) rr_sum = rr_sum - NCH_W;
        rr_idx = rr_sum[SEL_W-1:0];
    end

    // Fixed priority: lowest requesting index.
    always_comb begin
        fp_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_in[k]) fp_idx = SEL_W'(k);
        end
    end

    // Lock overrides either mode while the last winner keeps requesting.
    always_comb begin
        if (lock_in && req_in[last])
            win_idx = last;
        else if (ARB_MODE == 1)
            win_idx = fp_idx;
        else
            win_idx = rr_idx;
    end

    always_comb begin
        grant_out = '0;
        if (grant_en) grant_out[win_idx] = 1'b1;
    end

    // Output stage occupancy: EMPTY <-> FULL.
    always_comb begin
        state_nxt = state;
        if (load_ok) state_nxt = (|req_in) ? FULL : EMPTY;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= EMPTY;
        else             state <= state_nxt;
    end

    // Payload and arbitration state move only on a grant. With no requests,
    // the word is dropped from valid but data/sel keep their last value.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            data_out <= '0;
            sel_out  <= '0;
            ptr      <= '0;
            last     <= '0;
        end else if (grant_en) begin
            data_out <= ch_data[win_idx];
            sel_out  <= win_idx;
            last     <= win_idx;
            ptr      <= (win_idx == LAST_CH) ? '0 : win_idx + SEL_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance share the
// same stimulus. A behavioural model predicts grant and output per cycle.
module tb_rr_arb_mux;

    localparam int BW = 32;
    localparam int NC = 8;

    logic clk_in = 1'b0;
    logic reset_n_in = 1'b0;
    logic [NC-1:0]    req_in = '0;
    logic [NC*BW-1:0] data_in;
    logic lock_in = 1'b0;
    logic ready_in = 1'b1;

    logic [NC-1:0] g_rr, g_fp;
    logic          v_rr, v_fp;
    logic [BW-1:0] d_rr, d_fp;
    logic [2:0]    s_rr, s_fp;

    logic [BW-1:0] ch [NC];

    int errors = 0;
    int checks = 0;

    // model state, index 0 = round-robin DUT, 1 = fixed-priority DUT
    int          m_ptr [2];
    int          m_last[2];
    int          m_sel [2];
    logic        m_valid[2];
    logic [31:0] m_data[2];

    always #5 clk_in = ~clk_in;

    always_comb begin
        for (int i = 0; i < NC; i++) data_in[i*BW +: BW] = ch[i];
    end

    rr_arb_mux #(.BUS_WIDTH(BW), .NUM_CH(NC), .ARB_MODE(0)) u_rr (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req_in),
        .data_in(data_in), .lock_in(lock_in), .ready_in(ready_in),
        .grant_out(g_rr), .valid_out(v_rr), .data_out(d_rr), .sel_out(s_rr)
    );

    rr_arb_mux #(.BUS_WIDTH(BW), .NUM_CH(NC), .ARB_MODE(1)) u_fp (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req_in),
        .data_in(data_in), .lock_in(lock_in), .ready_in(ready_in),
        .grant_out(g_fp), .valid_out(v_fp), .data_out(d_fp), .sel_out(s_fp)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Winner from the rules: lock first, then lowest index or circular scan from ptr.
    function automatic int pick(input int mode, input int p, input int l,
                                input logic [7:0] rq, input logic lk);
        int c;
        if (rq == 8'h00) return -1;
        if (lk && rq[l]) return l;
        for (int k = 0; k < NC; k++) begin
            c = (mode == 1) ? k : (p + k) % NC;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_last[m] = 0; m_sel[m] = 0;
            m_valid[m] = 1'b0; m_data[m] = '0;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_valid_rr"}, 32'(v_rr), 32'(m_valid[0]));
        check({tag, "_data_rr"},  d_rr,      m_data[0]);
        check({tag, "_sel_rr"},   32'(s_rr), 32'(m_sel[0]));
        check({tag, "_valid_fp"}, 32'(v_fp), 32'(m_valid[1]));
        check({tag, "_data_fp"},  d_fp,      m_data[1]);
        check({tag, "_sel_fp"},   32'(s_fp), 32'(m_sel[1]));
    endtask

    // Called at posedge+1. Drives one cycle and checks grants before the edge
    // and registered outputs after it. gs returns the RR grant seen pre-edge.
    task automatic step(input logic [7:0] rq, input logic lk, input logic rd,
                        output logic [7:0] gs);
        int   w[2];
        logic lo[2];
        logic [7:0] eg[2];
        req_in = rq; lock_in = lk; ready_in = rd;
        for (int m = 0; m < 2; m++) begin
            lo[m] = !m_valid[m] || rd;
            w[m]  = pick(m, m_ptr[m], m_last[m], rq, lk);
            eg[m] = (lo[m] && w[m] >= 0) ? 8'(1 << w[m]) : 8'h00;
        end
        #3;
        check("grant_rr", 32'(g_rr), 32'(eg[0]));
        check("grant_fp", 32'(g_fp), 32'(eg[1]));
        gs = g_rr;
        @(posedge clk_in);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (lo[m]) begin
                if (w[m] >= 0) begin
                    m_data[m] = ch[w[m]]; m_sel[m] = w[m]; m_valid[m] = 1'b1;
                    m_ptr[m] = (w[m] + 1) % NC; m_last[m] = w[m];
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        check_outs("cyc");
    endtask

    // Reset pulse that starts between edges; outputs must clear at once.
    task automatic mid_reset();
        #1 reset_n_in = 1'b0;
        #1;
        model_reset();
        check_outs("rst_async");
        check("rst_grant_rr", 32'(g_rr), 32'h0);
        check("rst_grant_fp", 32'(g_fp), 32'h0);
        @(posedge clk_in);
        #1;
        check("rst_hold_valid", 32'(v_rr), 32'h0);
        reset_n_in = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic       lock;
        logic       ready;
        logic [7:0] gnt;
        logic [2:0] sel;
    } vec_t;

    initial begin
        vec_t tab[$];
        logic [7:0] gs;

        for (int i = 0; i < NC; i++) ch[i] = 32'hA5A5_0000 + 32'(i);
        model_reset();

        // full-throughput sweep from ptr=0: 0..7 then wrap to 0
        for (int i = 0; i <= NC; i++)
            tab.push_back('{8'hFF, 1'b0, 1'b1, 8'(1 << (i % NC)), 3'(i % NC)});
        // move ptr to 3, then alternate 7 / 2 across the wrap
        tab.push_back('{8'h04, 1'b0, 1'b1, 8'h04, 3'd2});
        tab.push_back('{8'h84, 1'b0, 1'b1, 8'h80, 3'd7});
        tab.push_back('{8'h84, 1'b0, 1'b1, 8'h04, 3'd2});
        tab.push_back('{8'h84, 1'b0, 1'b1, 8'h80, 3'd7});

        // reset state with requests present
        req_in = 8'hFF;
        #2;
        check_outs("reset");
        check("reset_grant_rr", 32'(g_rr), 32'h0);
        @(posedge clk_in);
        #1 reset_n_in = 1'b1;

        foreach (tab[i]) begin
            step(tab[i].req, tab[i].lock, tab[i].ready, gs);
            check("tab_grant", 32'(gs), 32'(tab[i].gnt));
            check("tab_sel",   32'(s_rr), 32'(tab[i].sel));
            check("tab_valid", 32'(v_rr), 32'h1);
        end

        // stall: channel 5 word must hold while ready is low
        ch[5] = 32'hA5A5_0005;
        step(8'h20, 1'b0, 1'b1, gs);
        for (int i = 0; i < 4; i++) begin
            step(8'hFF, 1'b0, 1'b0, gs);
            check("stall_grant", 32'(gs), 32'h0);
            check("stall_data",  d_rr, 32'hA5A5_0005);
            check("stall_sel",   32'(s_rr), 32'd5);
            check("stall_valid", 32'(v_rr), 32'h1);
        end
        step(8'hFF, 1'b0, 1'b1, gs);
        check("unstall_grant", 32'(gs), 32'h40);

        // fixed priority and lock on the fixed-priority instance
        for (int i = 0; i < 3; i++) begin
            step(8'h60, 1'b0, 1'b1, gs);
            check("fp_sel5", 32'(s_fp), 32'd5);
        end
        step(8'h40, 1'b0, 1'b1, gs);
        check("fp_sel6", 32'(s_fp), 32'd6);
        step(8'h60, 1'b1, 1'b1, gs);
        check("fp_lock6", 32'(s_fp), 32'd6);
        step(8'h60, 1'b0, 1'b1, gs);
        check("fp_unlock5", 32'(s_fp), 32'd5);

        // reset while holding a word, then first grant from ptr=0
        check("pre_reset_valid", 32'(v_rr), 32'h1);
        req_in = 8'hFF;
        mid_reset();
        step(8'h10, 1'b0, 1'b1, gs);
        check("post_reset_grant", 32'(gs), 32'h10);
        check("post_reset_sel", 32'(s_rr), 32'd4);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rq;
            for (int i = 0; i < NC; i++) ch[i] = $urandom;
            rq = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 9) == 0) rq = 8'h00;
            step(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), gs);
            if (n == 200) begin
                req_in = 8'hFF;
                mid_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
